// File: rtl/bw_mac_accum.sv
// -----------------------------------------------------------------------------
// bw_mac_accum
//
// Accumulates a group of signed products (as produced by multiplierMxN) into
// a signed sum. It also counts the products in the group and flags any
// signed overflow. A product with in_last set closes the group. The result
// is held until the downstream block accepts it, then everything clears for
// the next group.
//
// Build option:
//   BW_MAC_ACCUM_SAT_EN  defined   -> when an add overflows, the accumulator
//                                     clamps to the signed max or min, and
//                                     later products add to the clamped value.
//                        undefined -> the accumulator wraps modulo 2^ACC_W.
//   out_ovf is reported in both builds.
//
// State table:
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | no products held, waiting for the first one
//   ACC   | at least one product held, group still open
//   DONE  | result held on out_*, waiting for out_ready
//
// Parameters:
//   PROD_W     signed product width (default 10)
//   ACC_W      signed accumulator width, must exceed PROD_W (default 16)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   prod_in    signed product
//   in_valid   prod_in is valid
//   in_last    last product of the group (qualified by in_valid)
//   in_ready   a product can be accepted this cycle
//   out_data   signed group sum
//   out_count  products in the group, saturating at 255
//   out_ovf    sticky signed-overflow flag for the group
//   out_valid  out_data/out_count/out_ovf are valid
//   out_ready  downstream accepts the result
// -----------------------------------------------------------------------------
module bw_mac_accum #(
    parameter int PROD_W = 10,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [7:0]        out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              in_fire;
    logic              out_fire;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum_raw;
    logic [ACC_W-1:0]  acc_nxt;
    logic              ovf_now;
    logic [7:0]        count;
    logic              ovf;

    // in_ready depends only on state, so it never depends combinationally
    // on out_ready.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    state_nxt = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_fire && in_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // control outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACC: in_ready  = 1'b1;
            DONE:      out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Signed add. The add overflows only when both operands have the same
    // sign and the result's sign is different.
    assign prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign sum_raw  = acc + prod_ext;
    assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef BW_MAC_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The clamp direction follows the shared operand sign.
    always_comb begin
        acc_nxt = sum_raw;
        if (ovf_now) begin
            acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_nxt = sum_raw;
`endif

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (out_fire) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (in_fire) begin
            acc   <= acc_nxt;
            count <= (count == 8'hFF) ? count : count + 8'd1;
            ovf   <= ovf | ovf_now;
        end
    end

    // In DONE no product can be accepted, so these registers hold steady
    // until the result is taken.
    assign out_data  = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_bw_mac_accum.sv
module tb_bw_mac_accum;

    localparam int PROD_W = 10;
    localparam int ACC_W  = 16;
    localparam int MAXV   = (1 << (ACC_W - 1)) - 1;
    localparam int MINV   = -(1 << (ACC_W - 1));
    localparam int MODV   = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [PROD_W-1:0] prod_in;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_data;
    logic [7:0]        out_count;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;
    int grp[$];
    bit gaps_en  = 1'b1;

    bw_mac_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    n;
        logic [3:0][PROD_W-1:0] vals;
        int                    exp_data;
        int                    exp_count;
        bit                    exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer sum with overflow folded back into ACC_W range.
    task automatic model(output int d, output int c, output bit o);
        int acc_m;
        int s;
        acc_m = 0;
        c = 0;
        o = 1'b0;
        foreach (grp[i]) begin
            s = acc_m + grp[i];
            if (s > MAXV || s < MINV) begin
                o = 1'b1;
`ifdef BW_MAC_ACCUM_SAT_EN
                acc_m = (s > MAXV) ? MAXV : MINV;
`else
                acc_m = (s > MAXV) ? s - MODV : s + MODV;
`endif
            end else begin
                acc_m = s;
            end
            c = (c < 255) ? c + 1 : 255;
        end
        d = acc_m;
    endtask

    task automatic send_grp();
        int v;
        for (int i = 0; i < grp.size(); i++) begin
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                prod_in  = PROD_W'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            v        = grp[i];
            in_valid = 1'b1;
            prod_in  = v[PROD_W-1:0];
            in_last  = (i == grp.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input string nm, input int ed, input int ec, input bit eo);
        int waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({nm, "_valid"}, int'(out_valid), 1);
        repeat ($urandom_range(0, 3)) tick();
        chk({nm, "_data"}, int'($signed(out_data)), ed);
        chk({nm, "_count"}, int'(out_count), ec);
        chk({nm, "_ovf"}, int'(out_ovf), int'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_rdy_after"}, int'(in_ready), 1);
        chk({nm, "_vld_after"}, int'(out_valid), 0);
    endtask

    initial begin
        int d, c, n;
        bit o;
        bit big;
        int sgn;

        vecs[0] = '{n: 3, vals: {10'sd0, 10'sd100, -10'sd11, 10'sd55},
                    exp_data: 144, exp_count: 3, exp_ovf: 1'b0};
        vecs[1] = '{n: 1, vals: {10'sd0, 10'sd0, 10'sd0, -10'sd512},
                    exp_data: -512, exp_count: 1, exp_ovf: 1'b0};
        vecs[2] = '{n: 2, vals: {10'sd0, 10'sd0, 10'sd511, 10'sd511},
                    exp_data: 1022, exp_count: 2, exp_ovf: 1'b0};
        vecs[3] = '{n: 4, vals: {-10'sd512, -10'sd512, -10'sd512, -10'sd512},
                    exp_data: -2048, exp_count: 4, exp_ovf: 1'b0};
        vecs[4] = '{n: 2, vals: {10'sd0, 10'sd0, -10'sd1, 10'sd1},
                    exp_data: 0, exp_count: 2, exp_ovf: 1'b0};

        rst = 1'b1; prod_in = '0; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_count", int'(out_count), 0);
        chk("reset_ovf", int'(out_ovf), 0);

        // table vectors
        for (int k = 0; k < 5; k++) begin
            grp.delete();
            for (int j = 0; j < vecs[k].n; j++) grp.push_back(int'($signed(vecs[k].vals[j])));
            send_grp();
            chk($sformatf("vec%0d_latency", k), int'(out_valid), 1);
            chk($sformatf("vec%0d_ready_low", k), int'(in_ready), 0);
            collect($sformatf("vec%0d", k), vecs[k].exp_data, vecs[k].exp_count, vecs[k].exp_ovf);
        end

        // back-pressure: DONE ignores products while out_ready is low
        grp = '{3, 4};
        send_grp();
        in_valid = 1'b1; prod_in = 10'd99; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_data", int'($signed(out_data)), 7);
            chk("bp_count", int'(out_count), 2);
            tick();
        end
        in_valid = 1'b0;
        collect("bp", 7, 2, 1'b0);
        grp = '{5};
        send_grp();
        collect("bp_next", 5, 1, 1'b0);

        // overflow: 65 x 511
        gaps_en = 1'b0;
        grp.delete();
        repeat (65) grp.push_back(511);
        send_grp();
`ifdef BW_MAC_ACCUM_SAT_EN
        collect("ovf", 32767, 65, 1'b1);
`else
        collect("ovf", -32321, 65, 1'b1);
`endif

        // reset mid-group
        grp = '{20, 30};
        in_valid = 1'b1; in_last = 1'b0;
        prod_in = 10'd20; tick();
        prod_in = 10'd30; tick();
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_count", int'(out_count), 0);
        chk("midrst_data", int'(out_data), 0);
        grp = '{7};
        send_grp();
        collect("midrst", 7, 1, 1'b0);

        // reset discards a pending result
        grp = '{9};
        send_grp();
        rst = 1'b1; out_ready = 1'b0; tick(); rst = 1'b0;
        chk("donerst_valid", int'(out_valid), 0);
        chk("donerst_ready", int'(in_ready), 1);
        chk("donerst_count", int'(out_count), 0);

        // count saturation
        grp.delete();
        repeat (300) grp.push_back(1);
        send_grp();
        collect("sat_count", 300, 255, 1'b0);

        // randomized groups against the model
        gaps_en = 1'b1;
        for (int g = 0; g < 30; g++) begin
            grp.delete();
            big = ($urandom_range(0, 2) == 0);
            sgn = $urandom_range(0, 1);
            n = big ? $urandom_range(50, 100) : $urandom_range(1, 40);
            for (int j = 0; j < n; j++) begin
                if (big) grp.push_back(sgn ? -int'($urandom_range(400, 512)) : int'($urandom_range(400, 511)));
                else     grp.push_back(int'($urandom_range(0, 1023)) - 512);
            end
            model(d, c, o);
            send_grp();
            collect($sformatf("rand%0d", g), d, c, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bw_mac_accum.md
BW_MAC_ACCUM -- requirements
Module: bw_mac_accum

Interface
REQ-001 Parameter PROD_W, default 10: signed product width, matching multiplierMxN output p.
REQ-002 Parameter ACC_W, default 16: signed accumulator width; ACC_W SHALL be greater than PROD_W.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port prod_in  input  PROD_W: signed two's-complement product from multiplierMxN.
REQ-006 Port in_valid  input  1: prod_in is valid.
REQ-007 Port in_last  input  1: qualified by in_valid; marks the final product of a group.
REQ-008 Port in_ready  output  1: block can accept a product this cycle.
REQ-009 Port out_data  output  ACC_W: signed group sum.
REQ-010 Port out_count  output  8: number of products in the group, saturating at 255.
REQ-011 Port out_ovf  output  1: sticky; signed overflow occurred within the group.
REQ-012 Port out_valid  output  1: out_data, out_count and out_ovf are valid.
REQ-013 Port out_ready  input  1: downstream accepts the result.

Function
REQ-014 The input handshake SHALL complete when in_valid and in_ready are both 1 on a rising edge; the output handshake SHALL complete when out_valid and out_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE (no products held), ACC (at least one product held), DONE (result held).
REQ-016 Transitions:
- IDLE to ACC on an accepted product with in_last=0.
- IDLE or ACC to DONE on an accepted product with in_last=1.
- DONE to IDLE on the output handshake.
- Otherwise the FSM SHALL hold its state.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL be 1 only in DONE, asserting on the cycle after the in_last handshake; latency is 1 cycle.
REQ-019 Each accepted product SHALL be sign-extended to ACC_W bits and added to the accumulator.
REQ-020 The in_last product SHALL be included in out_data.
REQ-021 Signed overflow SHALL be detected when both operands share a sign and the raw sum's sign differs; detection SHALL set out_ovf.
REQ-022 out_count SHALL increment on each accepted product and saturate at 255.
REQ-023 In DONE, out_data, out_count and out_ovf SHALL remain stable until the output handshake.
REQ-024 On the output handshake, the accumulator, count and out_ovf SHALL clear; in_ready SHALL return to 1 the next cycle (no same-cycle bypass).
REQ-025 Products presented while in_ready=0 SHALL be ignored and SHALL NOT change any state.
REQ-026 A group of one product (in_last=1 accepted in IDLE) SHALL yield out_count=1 and out_data equal to the sign-extended product.

Reset
REQ-027 While rst=1 at a rising edge: state SHALL become IDLE and accumulator, out_data, out_count and out_ovf SHALL become 0.
REQ-028 Reset values of the control outputs SHALL be out_valid=0 and in_ready=1 from the first cycle after reset.
REQ-029 Reset SHALL take priority over any handshake in the same cycle; a partial group or pending result SHALL be discarded.

Configuration
REQ-030 Macro BW_MAC_ACCUM_SAT_EN defined: on overflow, the accumulator SHALL clamp to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) according to the operand sign, and SHALL continue accumulating from the clamped value.
REQ-031 Macro BW_MAC_ACCUM_SAT_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W; out_ovf SHALL still be reported.

Verification
REQ-032 Group: products 55, -11, 100, with in_last on 100 -> out_data=144, out_count=3, out_ovf=0, out_valid=1 one cycle after the last handshake.
REQ-033 Single-product group: prod_in=-512 with in_last=1 -> out_data=-512 (0xFE00), out_count=1.
REQ-034 Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0 throughout, outputs stable, no product absorbed; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-035 Overflow: 65 products of 511, last flagged -> SAT_EN defined gives out_data=32767, out_ovf=1; undefined gives out_data=-32321, out_ovf=1; out_count=65 in both builds.
REQ-036 Reset mid-group: accept 20 and 30, assert rst for one cycle, then send group 7 (last) -> out_data=7, out_count=1.
REQ-037 Count saturation: 300 products of 1 -> out_count=255, out_data=300.
